// File: rtl/sd_response_rx_if.sv
// Bundle between the SD command engine and the CMD-line response receiver.
// The master side arms the receiver and feeds bit strobes; the slave side is the receiver.
interface sd_response_rx_if;
   logic         sample_en;
   logic         cmd_in;
   logic         start;
   logic [2:0]   resp_type;
   logic [5:0]   exp_idx;
   logic         r2_is_csd;
   logic         busy;
   logic         done;
   logic         timeout;
   logic         crc_err;
   logic         frame_err;
   logic         cid_en;
   logic         csd_en;
   logic         ocr_en;
   logic         rca_en;
   logic         stat_en;
   logic [127:0] resp_data;
   logic [31:0]  ocr_data;
   logic [15:0]  rca_data;
   logic [63:0]  stat_data;

   modport master (
      output sample_en, cmd_in, start, resp_type, exp_idx, r2_is_csd,
      input  busy, done, timeout, crc_err, frame_err,
             cid_en, csd_en, ocr_en, rca_en, stat_en,
             resp_data, ocr_data, rca_data, stat_data
   );

   modport slave (
      input  sample_en, cmd_in, start, resp_type, exp_idx, r2_is_csd,
      output busy, done, timeout, crc_err, frame_err,
             cid_en, csd_en, ocr_en, rca_en, stat_en,
             resp_data, ocr_data, rca_data, stat_data
   );
endinterface

// File: rtl/sd_response_rx.sv
// SD CMD-line response receiver: deserialises R1/R1b/R2/R3/R6/R7, checks framing, CRC7 and index,
// then pulses register-bank write enables. Define SD_R1B_BUSY_EN to add the DAT0 busy wait after R1b.
module sd_response_rx #(
   parameter int unsigned RESP_TIMEOUT = 64
) (
   input logic clk,
   input logic reset,
`ifdef SD_R1B_BUSY_EN
   input logic dat0_in,
`endif
   sd_response_rx_if.slave bus
);
   localparam int unsigned CNT_W = $clog2(RESP_TIMEOUT + 1);
   localparam int unsigned SHR_W = 134;
   localparam logic [2:0]  T_R1  = 3'd1;
   localparam logic [2:0]  T_R1B = 3'd2;
   localparam logic [2:0]  T_R2  = 3'd3;
   localparam logic [2:0]  T_R3  = 3'd4;
   localparam logic [2:0]  T_R6  = 3'd5;
   localparam logic [2:0]  T_R7  = 3'd6;

   typedef enum logic [2:0] {
      IDLE, WAIT_START, RECV, CHECK
`ifdef SD_R1B_BUSY_EN
      , BUSY_WAIT
`endif
   } state_t;

   state_t           state;
   logic [2:0]       rtype;
   logic [5:0]       idx_q;
   logic             csd_q;
   logic [CNT_W-1:0] to_cnt;
   logic [7:0]       bit_cnt;
   logic [SHR_W-1:0] shreg;
   logic [6:0]       crc;

   logic             is_r2, is_r3, type_ok, last_bit, crc_upd, crc_fb;
   logic             frame_bad, crc_bad, clean;
   logic [7:0]       frame_bit;
   logic [SHR_W:0]   frame;
   logic [5:0]       idx_field, idx_exp;
   logic [6:0]       crc_next;
   logic [31:0]      r6_status;

   // Frame view including the bit on the line now, so checks resolve on the end-bit strobe.
   always_comb begin
      is_r2     = (rtype == T_R2);
      is_r3     = (rtype == T_R3);
      type_ok   = (bus.resp_type >= T_R1) && (bus.resp_type <= T_R7);
      frame     = {shreg, bus.cmd_in};
      frame_bit = (is_r2 ? 8'd134 : 8'd46) - bit_cnt;
      last_bit  = (frame_bit == 8'd0);
      crc_upd   = (frame_bit >= 8'd8) && (!is_r2 || (frame_bit <= 8'd127));
      crc_fb    = crc[6] ^ bus.cmd_in;
      crc_next  = {crc[5:0], 1'b0} ^ (crc_fb ? 7'h09 : 7'h00);
      idx_field = is_r2 ? frame[133:128] : frame[45:40];
      idx_exp   = (is_r2 || is_r3) ? 6'h3F : idx_q;
      frame_bad = (is_r2 ? frame[134] : frame[46]) | ~frame[0] | (idx_field != idx_exp);
      crc_bad   = !is_r3 && (crc != frame[7:1]);
      clean     = !frame_bad && !crc_bad;
      // R6 carries card status bits 23, 22, 19 and 12:0
      r6_status = {8'h00, frame[23], frame[22], 2'b00, frame[21], 6'b000000, frame[20:8]};
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state         <= IDLE;
         rtype         <= 3'd0;
         idx_q         <= 6'd0;
         csd_q         <= 1'b0;
         to_cnt        <= '0;
         bit_cnt       <= 8'd0;
         shreg         <= '0;
         crc           <= 7'd0;
         bus.busy      <= 1'b0;
         bus.done      <= 1'b0;
         bus.timeout   <= 1'b0;
         bus.crc_err   <= 1'b0;
         bus.frame_err <= 1'b0;
         bus.cid_en    <= 1'b0;
         bus.csd_en    <= 1'b0;
         bus.ocr_en    <= 1'b0;
         bus.rca_en    <= 1'b0;
         bus.stat_en   <= 1'b0;
         bus.resp_data <= 128'd0;
         bus.ocr_data  <= 32'd0;
         bus.rca_data  <= 16'd0;
         bus.stat_data <= 64'd0;
      end else begin
         bus.done      <= 1'b0;
         bus.timeout   <= 1'b0;
         bus.crc_err   <= 1'b0;
         bus.frame_err <= 1'b0;
         bus.cid_en    <= 1'b0;
         bus.csd_en    <= 1'b0;
         bus.ocr_en    <= 1'b0;
         bus.rca_en    <= 1'b0;
         bus.stat_en   <= 1'b0;
         case (state)
            IDLE: begin
               if (bus.start) begin
                  rtype <= bus.resp_type;
                  idx_q <= bus.exp_idx;
                  csd_q <= bus.r2_is_csd;
                  if (type_ok) begin
                     state    <= WAIT_START;
                     to_cnt   <= '0;
                     bus.busy <= 1'b1;
                  end else begin
                     bus.done <= 1'b1;
                  end
               end
            end
            WAIT_START: begin
               if (bus.sample_en) begin
                  if (!bus.cmd_in) begin
                     state   <= RECV;
                     bit_cnt <= 8'd0;
                     shreg   <= '0;
                     crc     <= 7'd0;
                  end else if (to_cnt == CNT_W'(RESP_TIMEOUT - 1)) begin
                     state       <= IDLE;
                     bus.busy    <= 1'b0;
                     bus.done    <= 1'b1;
                     bus.timeout <= 1'b1;
                  end else begin
                     to_cnt <= to_cnt + CNT_W'(1);
                  end
               end
            end
            RECV: begin
               if (bus.sample_en) begin
                  shreg   <= frame[SHR_W-1:0];
                  bit_cnt <= bit_cnt + 8'd1;
                  if (crc_upd) crc <= crc_next;
                  if (last_bit) begin
                     state         <= CHECK;
                     bus.done      <= 1'b1;
                     bus.frame_err <= frame_bad;
                     bus.crc_err   <= crc_bad;
                     if (clean) begin
                        case (rtype)
                           T_R1, T_R1B, T_R7: begin
                              bus.stat_en   <= 1'b1;
                              bus.stat_data <= {26'd0, frame[45:40], frame[39:8]};
                           end
                           T_R6: begin
                              bus.stat_en   <= 1'b1;
                              bus.rca_en    <= 1'b1;
                              bus.rca_data  <= frame[39:24];
                              bus.stat_data <= {26'd0, frame[45:40], r6_status};
                           end
                           T_R3: begin
                              bus.stat_en   <= 1'b1;
                              bus.ocr_en    <= 1'b1;
                              bus.ocr_data  <= frame[39:8];
                              bus.stat_data <= {26'd0, 6'h3F, 32'd0};
                           end
                           T_R2: begin
                              bus.cid_en    <= !csd_q;
                              bus.csd_en    <= csd_q;
                              bus.resp_data <= {frame[127:1], 1'b1};
                           end
                           default: ;
                        endcase
                     end
                  end
               end
            end
            CHECK: begin
`ifdef SD_R1B_BUSY_EN
               if (rtype == T_R1B && !bus.crc_err && !bus.frame_err) begin
                  state <= BUSY_WAIT;
               end else begin
                  state    <= IDLE;
                  bus.busy <= 1'b0;
               end
`else
               state    <= IDLE;
               bus.busy <= 1'b0;
`endif
            end
`ifdef SD_R1B_BUSY_EN
            BUSY_WAIT: begin
               if (bus.sample_en && dat0_in) begin
                  state    <= IDLE;
                  bus.busy <= 1'b0;
                  bus.done <= 1'b1;
               end
            end
`endif
            default: begin
               state    <= IDLE;
               bus.busy <= 1'b0;
            end
         endcase
      end
   end
endmodule

// File: tb/tb_sd_response_rx.sv
// Randomised self-checking bench for sd_response_rx; expected results come from a field-level
// frame model with CRC7 computed by polynomial division.
module tb_sd_response_rx;
   localparam logic [2:0] R1 = 3'd1, R1B = 3'd2, R2 = 3'd3, R3 = 3'd4, R6 = 3'd5, R7 = 3'd6;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   sd_response_rx_if bus ();
`ifdef SD_R1B_BUSY_EN
   logic dat0_in;
`endif

   sd_response_rx #(.RESP_TIMEOUT(64)) dut (
      .clk     (clk),
      .reset   (reset),
`ifdef SD_R1B_BUSY_EN
      .dat0_in (dat0_in),
`endif
      .bus     (bus)
   );

   int total = 0;
   int bad = 0;
   int done_cnt = 0;
   int exp_done = 0;

   logic [127:0] m_resp;
   logic [31:0]  m_ocr;
   logic [15:0]  m_rca;
   logic [63:0]  m_stat;

   always @(negedge clk) if (bus.done === 1'b1) done_cnt++;

   task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
      end
   endtask

   // Remainder of msg * x^7 divided by x^7 + x^3 + 1
   function automatic logic [6:0] crc7(input logic [127:0] msg, input int n);
      logic [134:0] r;
      r = {msg, 7'd0};
      for (int i = n + 6; i >= 7; i--)
         if (r[i]) r[i -: 8] = r[i -: 8] ^ 8'h89;
      return r[6:0];
   endfunction

   function automatic logic [135:0] mk48(input logic [5:0] idx, input logic [31:0] pl, input logic r3);
      logic [135:0] f;
      logic [6:0]   c;
      f = '0;
      f[47:8] = {2'b00, idx, pl};
      c = r3 ? 7'h7F : crc7(128'(f[47:8]), 40);
      f[7:0] = {c, 1'b1};
      return f;
   endfunction

   function automatic logic [135:0] mk136(input logic [119:0] pl);
      logic [135:0] f;
      f[135:8] = {2'b00, 6'h3F, pl};
      f[7:0] = {crc7(128'(pl), 120), 1'b1};
      return f;
   endfunction

   task automatic arm(input logic [2:0] t, input logic [5:0] ei, input logic csd);
      bus.start = 1'b1; bus.resp_type = t; bus.exp_idx = ei; bus.r2_is_csd = csd;
      @(posedge clk); #1;
      bus.start = 1'b0;
      bus.resp_type = 3'($urandom); bus.exp_idx = 6'($urandom); bus.r2_is_csd = 1'($urandom);
   endtask

   // Idle cycles carry junk start/cmd levels that a busy receiver must ignore.
   task automatic strobe(input logic b, input int gap);
      for (int g = 0; g < gap; g++) begin
         bus.start = 1'($urandom); bus.resp_type = 3'($urandom); bus.cmd_in = 1'($urandom);
         @(posedge clk); #1;
      end
      bus.start = 1'b0;
      bus.sample_en = 1'b1; bus.cmd_in = b;
      @(posedge clk); #1;
      bus.sample_en = 1'b0; bus.cmd_in = 1'($urandom);
   endtask

   task automatic idle(input int n);
      bus.start = 1'b0;
      for (int i = 0; i < n; i++) begin
         @(posedge clk); #1;
         bus.sample_en = 1'($urandom); bus.cmd_in = 1'($urandom);
      end
      @(posedge clk); #1;
      bus.sample_en = 1'b0;
   endtask

   task automatic run_none(input logic [2:0] t);
      arm(t, 6'($urandom), 1'($urandom));
      @(negedge clk);
      check("none_done", 128'(bus.done), 128'(1'b1));
      check("none_flags", 128'({bus.timeout, bus.crc_err, bus.frame_err}), 128'(0));
      check("none_busy", 128'(bus.busy), 128'(0));
      check("none_en", 128'({bus.cid_en, bus.csd_en, bus.ocr_en, bus.rca_en, bus.stat_en}), 128'(0));
      exp_done++;
   endtask

   task automatic run_frame(input logic [2:0] t, input logic [5:0] ei, input logic csd,
                            input logic [135:0] fr, input int len, input int pre);
      logic fe, ce, ok, inj, tx;
      logic [5:0] idxf, idxe;
      logic [6:0] crcc;
      logic [31:0] st;
      int d0;
      arm(t, ei, csd);
      d0 = done_cnt;
      for (int i = 0; i < pre; i++) strobe(1'b1, int'($urandom_range(0, 2)));
      for (int i = len - 1; i >= 0; i--) strobe(fr[i], int'($urandom_range(0, 2)));
      check("early_done", 128'(done_cnt), 128'(d0));
      if (t == R2) begin
         tx = fr[134]; idxf = fr[133:128]; crcc = crc7(128'(fr[127:8]), 120);
      end else begin
         tx = fr[46]; idxf = fr[45:40]; crcc = crc7(128'(fr[47:8]), 40);
      end
      idxe = (t == R2 || t == R3) ? 6'h3F : ei;
      fe = tx | ~fr[0] | (idxf != idxe);
      ce = (t != R3) && (fr[7:1] != crcc);
      ok = !fe && !ce;
      if (ok) begin
         case (t)
            R1, R1B, R7: m_stat = {26'd0, fr[45:40], fr[39:8]};
            R6: begin
               m_rca  = fr[39:24];
               st     = 32'd0;
               st[23] = fr[23]; st[22] = fr[22]; st[19] = fr[21]; st[12:0] = fr[20:8];
               m_stat = {26'd0, fr[45:40], st};
            end
            R3: begin m_ocr = fr[39:8]; m_stat = {26'd0, 6'h3F, 32'd0}; end
            R2: m_resp = {fr[127:1], 1'b1};
            default: ;
         endcase
      end
      @(negedge clk);
      check("done", 128'(bus.done), 128'(1'b1));
      check("timeout", 128'(bus.timeout), 128'(0));
      check("crc_err", 128'(bus.crc_err), 128'(ce));
      check("frame_err", 128'(bus.frame_err), 128'(fe));
      check("stat_en", 128'(bus.stat_en), 128'(ok && t != R2));
      check("rca_en", 128'(bus.rca_en), 128'(ok && t == R6));
      check("ocr_en", 128'(bus.ocr_en), 128'(ok && t == R3));
      check("cid_en", 128'(bus.cid_en), 128'(ok && t == R2 && !csd));
      check("csd_en", 128'(bus.csd_en), 128'(ok && t == R2 && csd));
      check("stat_data", 128'(bus.stat_data), 128'(m_stat));
      check("rca_data", 128'(bus.rca_data), 128'(m_rca));
      check("ocr_data", 128'(bus.ocr_data), 128'(m_ocr));
      check("resp_data", bus.resp_data, m_resp);
      exp_done++;
      inj = 1'($urandom);
`ifdef SD_R1B_BUSY_EN
      if (t == R1B && ok) begin
         inj = 1'b0;
         @(negedge clk);
         check("bw_busy", 128'(bus.busy), 128'(1'b1));
         dat0_in = 1'b1;
         strobe(1'b1, 1);
         dat0_in = 1'b0;
         @(negedge clk);
         check("bw_done", 128'(bus.done), 128'(1'b1));
         check("bw_flags", 128'({bus.timeout, bus.crc_err, bus.frame_err}), 128'(0));
         exp_done++;
      end
`endif
      if (inj) begin
         // start landing on the CHECK cycle must not re-arm
         bus.start = 1'b1; bus.resp_type = R1;
         @(posedge clk); #1;
         bus.start = 1'b0;
      end
      @(negedge clk);
      check("post_busy", 128'(bus.busy), 128'(0));
      check("post_done", 128'(bus.done), 128'(0));
   endtask

   initial begin
      #3_000_000;
      $display("FAIL watchdog expired t=%0t", $time);
      $fatal(1, "watchdog");
   end

   initial begin
      logic [135:0] fr;
      logic [127:0] rnd;
      logic [2:0]   t;
      logic [5:0]   ei;
      logic         csd;
      int           len, cor, k, d0;

      reset = 1'b1;
      bus.sample_en = 1'b0; bus.cmd_in = 1'b1; bus.start = 1'b0;
      bus.resp_type = 3'd0; bus.exp_idx = 6'd0; bus.r2_is_csd = 1'b0;
`ifdef SD_R1B_BUSY_EN
      dat0_in = 1'b0;
`endif
      m_resp = '0; m_ocr = '0; m_rca = '0; m_stat = '0;
      repeat (3) @(posedge clk);
      #1 reset = 1'b0;
      @(negedge clk);
      check("rst_busy", 128'(bus.busy), 128'(0));
      check("rst_done", 128'(bus.done), 128'(0));
      check("rst_stat", 128'(bus.stat_data), 128'(0));
      check("rst_resp", bus.resp_data, 128'(0));
      idle(2);

      // R1 CMD17, then the same frame with CRC bit 3 flipped
      fr = mk48(6'd17, 32'h0000_0900, 1'b0);
      run_frame(R1, 6'd17, 1'b0, fr, 48, 5);
      check("r1_stat_const", 128'(bus.stat_data), 128'(64'h0000_0011_0000_0900));
      idle(2);
      fr[4] = ~fr[4];
      run_frame(R1, 6'd17, 1'b0, fr, 48, 3);
      check("r1_crc_hold", 128'(bus.stat_data), 128'(64'h0000_0011_0000_0900));
      idle(2);

      // Timeout after 64 idle-high strobes
      arm(R1, 6'd17, 1'b0);
      d0 = done_cnt;
      for (int i = 0; i < 63; i++) strobe(1'b1, int'($urandom_range(0, 2)));
      check("to_early", 128'(done_cnt), 128'(d0));
      strobe(1'b1, 1);
      @(negedge clk);
      check("to_done", 128'(bus.done), 128'(1'b1));
      check("to_flag", 128'(bus.timeout), 128'(1'b1));
      check("to_busy", 128'(bus.busy), 128'(0));
      check("to_en", 128'(bus.stat_en), 128'(0));
      exp_done++;
      idle(2);

      fr = mk48(6'd3, {16'h1234, 16'h0520}, 1'b0);
      run_frame(R6, 6'd3, 1'b0, fr, 48, 2);
      check("r6_rca_const", 128'(bus.rca_data), 128'(16'h1234));
      check("r6_stat_const", 128'(bus.stat_data[31:0]), 128'(32'h0000_0520));
      idle(2);

      fr = mk48(6'h3F, 32'h80FF_8000, 1'b1);
      run_frame(R3, 6'd41, 1'b0, fr, 48, 4);
      check("r3_ocr_const", 128'(bus.ocr_data), 128'(32'h80FF_8000));
      idle(2);

      rnd = {$urandom, $urandom, $urandom, $urandom};
      run_frame(R2, 6'd2, 1'b0, mk136(rnd[119:0]), 136, 1);
      idle(2);

      // Start bit on the strobe where the idle count would expire
      run_frame(R7, 6'd8, 1'b0, mk48(6'd8, 32'h0000_01AA, 1'b0), 48, 63);
      idle(2);
      run_none(3'd0);
      idle(2);

      // Reset during R2 reception aborts silently and clears the buses
      arm(R2, 6'd2, 1'b1);
      strobe(1'b0, 0);
      for (int i = 0; i < 60; i++) strobe(1'($urandom), 0);
      reset = 1'b1;
      @(posedge clk); #1;
      @(posedge clk); #1;
      reset = 1'b0;
      m_resp = '0; m_ocr = '0; m_rca = '0; m_stat = '0;
      @(negedge clk);
      check("rr_busy", 128'(bus.busy), 128'(0));
      check("rr_resp", bus.resp_data, 128'(0));
      check("rr_stat", 128'(bus.stat_data), 128'(0));
      idle(5);
      check("rr_no_done", 128'(done_cnt), 128'(exp_done));

      for (int n = 0; n < 40; n++) begin
         t   = 3'($urandom_range(0, 7));
         ei  = 6'($urandom);
         csd = 1'($urandom);
         if (t == 3'd0 || t == 3'd7) begin
            run_none(t);
         end else begin
            if (t == R2) begin
               rnd = {$urandom, $urandom, $urandom, $urandom};
               fr  = mk136(rnd[119:0]);
               len = 136;
            end else begin
               fr  = mk48((t == R3) ? 6'h3F : ei, $urandom, t == R3);
               len = 48;
            end
            cor = int'($urandom_range(0, 9));
            case (cor)
               0: begin k = int'($urandom_range(1, 7)); fr[k] = ~fr[k]; end
               1: fr[0] = 1'b0;
               2: if (t == R2) fr[134] = 1'b1; else fr[46] = 1'b1;
               3: if (t == R2) fr[128] = ~fr[128];
                  else if (t == R3) fr[40] = ~fr[40];
                  else ei = ei ^ 6'h01;
               default: ;
            endcase
            run_frame(t, ei, csd, fr, len, int'($urandom_range(0, 63)));
         end
         idle(int'($urandom_range(1, 4)));
      end

      check("done_count", 128'(done_cnt), 128'(exp_done));
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
